// File: rtl/memory_arbiter.sv
// Arbitrates one multi-cycle backing-memory port between the instruction-fetch
// and data requesters, with data priority and a bounded-starvation rule for fetches.
module memory_arbiter #(
  parameter int MAX_D_STREAK = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        l1i_request,
  input  logic [31:0] l1i_address,
  output logic        l1i_ready,
  output logic [31:0] l1i_output_data,
  input  logic        l1d_request,
  input  logic        l1d_write,
  input  logic [31:0] l1d_address,
  input  logic [31:0] l1d_input_data,
  output logic        l1d_ready,
  output logic [31:0] l1d_output_data,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_output_data
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] d_streak;
  logic       grant_i;
  logic       grant_d;
  logic       complete_i;
  logic       complete_d;

  function automatic logic [3:0] streak_inc(input logic [3:0] cur);
    return (cur >= STREAK_LIMIT) ? STREAK_LIMIT : cur + 4'd1;
  endfunction

  assign complete_i = (state == BUSY_I) && mem_ready;
  assign complete_d = (state == BUSY_D) && mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pending fetch forces its grant once data has won STREAK_LIMIT times in a row.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (l1d_request && !(l1i_request && (d_streak == STREAK_LIMIT))) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (l1i_request) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ready) state_next = DONE_I;
      BUSY_D:  if (mem_ready) state_next = DONE_D;
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_streak        <= '0;
      mem_request     <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_input_data  <= '0;
      l1i_ready       <= 1'b0;
      l1d_ready       <= 1'b0;
      l1i_output_data <= '0;
      l1d_output_data <= '0;
    end else begin
      l1i_ready <= complete_i;
      l1d_ready <= complete_d;
      if (grant_i) begin
        mem_request    <= 1'b1;
        mem_write      <= 1'b0;
        mem_address    <= l1i_address;
        mem_input_data <= '0;
        d_streak       <= '0;
      end else if (grant_d) begin
        mem_request    <= 1'b1;
        mem_write      <= l1d_write;
        mem_address    <= l1d_address;
        mem_input_data <= l1d_input_data;
        d_streak       <= l1i_request ? streak_inc(d_streak) : 4'd0;
      end else if (complete_i || complete_d) begin
        mem_request <= 1'b0;
      end
      if (complete_i) begin
        l1i_output_data <= mem_output_data;
      end
      if (complete_d) begin
        l1d_output_data <= mem_write ? 32'd0 : mem_output_data;
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one multi-cycle backing-memory port between the instruction-fetch (l1i) and data (l1d) requesters. Each requester uses a request/ready handshake. The arbiter serialises the accepted requests onto the memory port and returns read data to the requester that was granted. Data accesses have priority, with a bounded-starvation rule for fetches. The block sits between the L1 caches and the ROM/RAM backing store, and lets that backing store have non-zero, variable latency.

## Interface
- MAX_D_STREAK, 2: maximum number of consecutive l1d grants while an l1i request is pending (range 1–15).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- l1i_request  in  1  fetch request; held high with a stable address until l1i_ready.
- l1i_address  in  32  fetch byte address.
- l1i_ready  out  1  one-cycle pulse: fetch complete, l1i_output_data valid.
- l1i_output_data  out  32  fetched word.
- l1d_request  in  1  data request; held high with stable fields until l1d_ready.
- l1d_write  in  1  1 = write, 0 = read.
- l1d_address  in  32  data byte address.
- l1d_input_data  in  32  write data.
- l1d_ready  out  1  one-cycle pulse: data access complete.
- l1d_output_data  out  32  read word; 0 after a write.
- mem_request  out  1  memory transaction active; held until mem_ready.
- mem_write  out  1  transaction is a write.
- mem_address  out  32  transaction address.
- mem_input_data  out  32  write data to memory.
- mem_ready  in  1  memory completes the transaction in this cycle.
- mem_output_data  in  32  read data; valid while mem_ready=1.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE transitions:
  - Both requests high: grant l1d, unless d_streak == MAX_D_STREAK, in which case grant l1i.
  - Only one request high: grant that requester.
  - Granting latches address, write flag and write data into the mem_* registers. The state moves to BUSY_I or BUSY_D, and mem_request=1.
- BUSY_x:
  - mem_request, mem_write, mem_address and mem_input_data are held constant.
  - On mem_ready=1: latch mem_output_data (or 0 for a write) into the requester's output_data register, clear mem_request, and move to DONE_x.
- DONE_x:
  - The requester's ready=1 for exactly this cycle.
  - Next state is IDLE.
- d_streak is a 4-bit counter:
  - Increments on each l1d grant made while l1i_request=1.
  - Saturates at MAX_D_STREAK.
  - Clears on every l1i grant and on any l1d grant made while l1i_request=0.
- Requesters must deassert request at the rising edge where they sample ready=1. A request still high in the following IDLE cycle is treated as a new transaction.
- Requests arriving during BUSY/DONE are not sampled until IDLE.
- Output data registers hold their last value until the next completion for that requester.
- mem_write=0 and mem_input_data=0 for fetches.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, d_streak=0.
  - mem_request=0, mem_write=0, mem_address=0, mem_input_data=0.
  - l1i_ready=0, l1d_ready=0, l1i_output_data=0, l1d_output_data=0.
- Cycle sequence:
  - Request seen in IDLE at cycle 0.
  - mem_request=1 from cycle 1.
  - mem_ready at cycle k ≥ 1.
  - Ready pulse at cycle k+1.
  - IDLE at cycle k+2.
- Minimum latency is 2 cycles from request to ready, with mem_ready in cycle 1. Back-to-back transactions therefore take at least 3 cycles each.
- mem_ready sampled while not in BUSY is ignored.
- Reset mid-transaction:
  - All outputs drop asynchronously to their reset values.
  - The in-flight access is abandoned and no ready pulse is issued.
  - A write may or may not have reached memory.
- l1i and l1d ready are never both high in the same cycle.

## Test plan
- Single fetch, mem_ready in the first BUSY cycle. l1i_address=0x10, mem_output_data=0xDEADBEEF → mem_address=0x10 at cycle 1; l1i_ready=1 with l1i_output_data=0xDEADBEEF at cycle 2 only.
- Data write with 3-cycle memory latency. l1d_address=0x20, l1d_input_data=0x5A5A → mem_request/mem_write held for 3 cycles; l1d_ready pulses once with l1d_output_data=0.
- Simultaneous requests, both held continuously, MAX_D_STREAK=2 → grant order D, D, I, D, D, I; d_streak returns to 0 after each I grant.
- A request that rises during BUSY_D is not sampled until IDLE. The in-progress mem_address/mem_write stay unchanged until mem_ready.
- Reset asserted during BUSY_I with mem_request=1 → all outputs 0 immediately. After release, a new l1d read completes normally with latency 2.
- A spurious mem_ready in IDLE or DONE produces no ready pulse and no change to the output data registers.
